// File: rtl/reg_file_mp_if.sv
// Register-file port bundle: two byte-enabled write ports plus NUM_RD packed read ports.
// The datapath drives through master; the register file implements slave.
interface reg_file_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic                       RegWrite0;
    logic [ADDR_W-1:0]          WN0;
    logic [DATA_W-1:0]          WD0;
    logic [DATA_W/8-1:0]        BE0;
    logic                       RegWrite1;
    logic [ADDR_W-1:0]          WN1;
    logic [DATA_W-1:0]          WD1;
    logic [DATA_W/8-1:0]        BE1;
    logic [NUM_RD*ADDR_W-1:0]   RN;
    logic [NUM_RD*DATA_W-1:0]   RD;

    modport master (
        output RegWrite0, WN0, WD0, BE0,
        output RegWrite1, WN1, WD1, BE1,
        output RN,
        input  RD
    );

    modport slave (
        input  RegWrite0, WN0, WD0, BE0,
        input  RegWrite1, WN1, WD1, BE1,
        input  RN,
        output RD
    );
endinterface

// File: rtl/reg_file_mp.sv
// Multi-port register file: 2 byte-enabled writes (port 1 wins per byte), NUM_RD combinational reads.
// Write-to-read latency is 0 cycles with BYPASS, else 1; no handshake, every write is accepted.
module reg_file_mp #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 5,
    parameter int NUM_RD  = 2,
    parameter int BYPASS  = 1,
    parameter int ZERO_R0 = 1
) (
    input  logic          clk,
    input  logic          rst,
    reg_file_mp_if.slave  bus
);
    localparam int DEPTH = 1 << ADDR_W;
    localparam int NB    = DATA_W / 8;

    logic [DATA_W-1:0] regs [DEPTH];
    logic              wr0_ok;
    logic              wr1_ok;

    assign wr0_ok = bus.RegWrite0 && !((ZERO_R0 != 0) && (bus.WN0 == '0));
    assign wr1_ok = bus.RegWrite1 && !((ZERO_R0 != 0) && (bus.WN1 == '0));

    // Port 1 lanes are assigned last so they override port 0 on a shared address.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else begin
            for (int b = 0; b < NB; b++) begin
                if (wr0_ok && bus.BE0[b]) begin
                    regs[bus.WN0][8*b +: 8] <= bus.WD0[8*b +: 8];
                end
            end
            for (int b = 0; b < NB; b++) begin
                if (wr1_ok && bus.BE1[b]) begin
                    regs[bus.WN1][8*b +: 8] <= bus.WD1[8*b +: 8];
                end
            end
        end
    end

    for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
        logic [ADDR_W-1:0] rn;
        logic [DATA_W-1:0] rd;

        assign rn = bus.RN[k*ADDR_W +: ADDR_W];

        // Forwarding follows the same lane priority as the write path and is muted during reset.
        always_comb begin
            rd = regs[rn];
            if ((BYPASS != 0) && !rst) begin
                for (int b = 0; b < NB; b++) begin
                    if (bus.RegWrite0 && (bus.WN0 == rn) && bus.BE0[b]) begin
                        rd[8*b +: 8] = bus.WD0[8*b +: 8];
                    end
                    if (bus.RegWrite1 && (bus.WN1 == rn) && bus.BE1[b]) begin
                        rd[8*b +: 8] = bus.WD1[8*b +: 8];
                    end
                end
            end
            if ((ZERO_R0 != 0) && (rn == '0)) begin
                rd = '0;
            end
        end

        assign bus.RD[k*DATA_W +: DATA_W] = rd;
    end
endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp (BYPASS=1, ZERO_R0=1): directed scenarios followed by random traffic
// checked against an array model with byte-mask merging.
module tb_reg_file_mp;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    reg_file_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

    reg_file_mp #(
        .DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR), .BYPASS(1), .ZERO_R0(1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    logic [DW-1:0] mem [32];
    int errors = 0;
    int checks = 0;

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        logic [31:0] m;
        m = '0;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) m = m | (32'hFF << (8 * b));
        end
        return m;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [3:0] be);
        return (old & ~lane_mask(be)) | (wd & lane_mask(be));
    endfunction

    // Expected read value seen combinationally during the current cycle.
    function automatic logic [31:0] model_read(input logic [4:0] a);
        logic [31:0] v;
        if (a == 5'd0) return 32'h0;
        v = mem[a];
        if (!rst) begin
            if (bus.RegWrite0 && bus.WN0 == a) v = merge(v, bus.WD0, bus.BE0);
            if (bus.RegWrite1 && bus.WN1 == a) v = merge(v, bus.WD1, bus.BE1);
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic check_reads(input string tag);
        for (int k = 0; k < NR; k++) begin
            check($sformatf("%s rd%0d", tag, k), bus.RD[k*DW +: DW], model_read(bus.RN[k*AW +: AW]));
        end
    endtask

    task automatic clock_edge();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < 32; i++) mem[i] = '0;
        end else begin
            if (bus.RegWrite0 && bus.WN0 != 5'd0) mem[bus.WN0] = merge(mem[bus.WN0], bus.WD0, bus.BE0);
            if (bus.RegWrite1 && bus.WN1 != 5'd0) mem[bus.WN1] = merge(mem[bus.WN1], bus.WD1, bus.BE1);
        end
        @(negedge clk);
    endtask

    task automatic idle();
        rst = 1'b0;
        bus.RegWrite0 = 1'b0;
        bus.WN0 = 'x;
        bus.WD0 = $urandom;
        bus.BE0 = 'x;
        bus.RegWrite1 = 1'b0;
        bus.WN1 = 'x;
        bus.WD1 = $urandom;
        bus.BE1 = 'x;
    endtask

    function automatic logic [4:0] pick_addr();
        if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
        return 5'($urandom_range(0, 7));
    endfunction

    initial begin
        idle();
        bus.RN = '0;
        rst = 1'b1;
        clock_edge();

        // Reset leaves every register reading zero
        idle();
        bus.RN = {5'd31, 5'd1};
        #1;
        check("t1 rd0", bus.RD[0 +: DW], 32'h0);
        check("t1 rd1", bus.RD[DW +: DW], 32'h0);

        // Plain writes
        bus.RegWrite0 = 1'b1; bus.WN0 = 5'd1; bus.WD0 = 32'd200; bus.BE0 = 4'hF;
        #1 check_reads("t2 fwd");
        clock_edge();
        idle();
        bus.RN = {5'd31, 5'd1};
        #1 check("t2 reg1", bus.RD[0 +: DW], 32'd200);
        bus.RegWrite0 = 1'b1; bus.WN0 = 5'd7; bus.WD0 = 32'd300; bus.BE0 = 4'hF;
        clock_edge();
        idle();
        bus.RN = {5'd7, 5'd1};
        #1;
        check("t2 reg7", bus.RD[DW +: DW], 32'd300);
        check("t2 reg1 kept", bus.RD[0 +: DW], 32'd200);

        // Same-address conflict, port 1 wins its enabled lanes
        bus.RegWrite0 = 1'b1; bus.WN0 = 5'd5; bus.WD0 = 32'hAAAAAAAA; bus.BE0 = 4'hF;
        bus.RegWrite1 = 1'b1; bus.WN1 = 5'd5; bus.WD1 = 32'h11223344; bus.BE1 = 4'b0101;
        bus.RN = {5'd5, 5'd5};
        #1 check("t3 fwd", bus.RD[0 +: DW], 32'hAA22AA44);
        clock_edge();
        idle();
        bus.RN = {5'd5, 5'd5};
        #1;
        check("t3 reg5 rd0", bus.RD[0 +: DW], 32'hAA22AA44);
        check("t3 reg5 rd1", bus.RD[DW +: DW], 32'hAA22AA44);

        // Same-cycle bypass
        bus.RN = {5'd3, 5'd3};
        #1 check("t4 before", bus.RD[0 +: DW], 32'h0);
        bus.RegWrite1 = 1'b1; bus.WN1 = 5'd3; bus.WD1 = 32'hDEADBEEF; bus.BE1 = 4'hF;
        #1 check("t4 bypass", bus.RD[0 +: DW], 32'hDEADBEEF);
        clock_edge();
        idle();
        #1 check("t4 stored", bus.RD[DW +: DW], 32'hDEADBEEF);

        // Register 0
        bus.RegWrite0 = 1'b1; bus.WN0 = 5'd0; bus.WD0 = 32'hFFFFFFFF; bus.BE0 = 4'hF;
        bus.RN = {5'd0, 5'd0};
        #1 check("t5 same cycle", bus.RD[0 +: DW], 32'h0);
        clock_edge();
        idle();
        #1 check("t5 after", bus.RD[0 +: DW], 32'h0);

        // Reset overrides a concurrent write
        bus.RegWrite0 = 1'b1; bus.WN0 = 5'd9; bus.WD0 = 32'h1234; bus.BE0 = 4'hF;
        clock_edge();
        idle();
        bus.RN = {5'd9, 5'd9};
        rst = 1'b1;
        bus.RegWrite0 = 1'b1; bus.WN0 = 5'd9; bus.WD0 = 32'h5678; bus.BE0 = 4'hF;
        #1 check("t6 no fwd in rst", bus.RD[0 +: DW], 32'h1234);
        clock_edge();
        idle();
        #1;
        check("t6 cleared", bus.RD[0 +: DW], 32'h0);
        check("t5 reg7 cleared", model_read(5'd7) | bus.RD[0 +: DW], 32'h0);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            rst = ($urandom_range(0, 59) == 0);
            bus.RegWrite0 = 1'($urandom_range(0, 1));
            bus.WN0 = bus.RegWrite0 ? pick_addr() : 'x;
            bus.WD0 = $urandom;
            bus.BE0 = 4'($urandom_range(0, 15));
            bus.RegWrite1 = 1'($urandom_range(0, 1));
            bus.WN1 = bus.RegWrite1 ? pick_addr() : 'x;
            bus.WD1 = $urandom;
            bus.BE1 = 4'($urandom_range(0, 15));
            bus.RN = {pick_addr(), pick_addr()};
            #1 check_reads("rand");
            clock_edge();
        end

        idle();
        for (int a = 0; a < 32; a++) begin
            bus.RN = {5'(a), 5'(31 - a)};
            #1 check_reads("final");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
